// File: rtl/sm83_bus_pkg.sv
// Shared types and helpers for the sm83 internal-bus arbiter:
// FSM state encoding, the precharged bus level and the round-robin pick function.
package sm83_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCHG = 2'd1,
        EVAL = 2'd2
    } bus_state_t;

    localparam logic BUS_IDLE_LEVEL = 1'b1;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    // First set request at or after ptr, wrapping modulo n; one-hot result, zero if none.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] onehot;
        logic [PTR_W-1:0]   idx;
        onehot = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % n);
            if ((k < n) && (onehot == '0) && req[idx]) begin
                onehot[idx] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/sm83_rr_picker.sv
// Combinational round-robin priority select: one-hot winner plus its index.
module sm83_rr_picker
    import sm83_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_REQ-1:0] pick_full;
    logic               unused_hi;

    always_comb begin
        pick_full = rr_pick(MAX_REQ'(req), PTR_W'(ptr), N_REQ);
        gnt       = pick_full[N_REQ-1:0];
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Bits above N_REQ are always zero; folded here so they count as consumed.
    assign unused_hi = ^pick_full;

endmodule

// File: rtl/sm83_bus_arbiter.sv
// Arbiter for the precharged wired-NOR internal bus: round-robin grant,
// precharge/evaluate beats, burst-length limit and abort on dropped request.
module sm83_bus_arbiter
    import sm83_bus_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W         = 8,
    parameter int PCHG_CYC  = 1,
    parameter int MAX_BEATS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   last,
    input  logic [N_REQ*W-1:0] wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic               pchg,
    output logic               bus_valid,
    output logic [W-1:0]       bus_data,
    output logic               forced
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BW    = $clog2(MAX_BEATS + 1);
    localparam int PW    = $clog2(PCHG_CYC + 1);

    localparam logic [PW-1:0]    PCHG_LAST  = PW'(PCHG_CYC - 1);
    localparam logic [BW-1:0]    BEAT_LIMIT = BW'(MAX_BEATS);
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(N_REQ - 1);

    bus_state_t       state;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [BW-1:0]    beat_cnt;
    logic [PW-1:0]    pchg_cnt;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [BW-1:0]    beat_next;
    logic             own_req;
    logic             own_last;
    logic [W-1:0]     own_data;

    sm83_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Only the granted requester's lines matter; everything else is ignored.
    always_comb begin
        next_ptr  = (g_idx == IDX_TOP) ? '0 : g_idx + IDX_W'(1);
        beat_next = beat_cnt + BW'(1);
        own_req   = req[g_idx];
        own_last  = last[g_idx];
        own_data  = wdata[g_idx*W +: W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= '0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            pchg_cnt  <= '0;
            pchg      <= 1'b0;
            bus_valid <= 1'b0;
            bus_data  <= {W{BUS_IDLE_LEVEL}};
            forced    <= 1'b0;
        end else begin
            forced <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= pick_gnt;
                        g_idx    <= pick_idx;
                        state    <= PCHG;
                        pchg     <= 1'b1;
                        pchg_cnt <= '0;
                        beat_cnt <= '0;
                    end
                end

                PCHG: begin
                    if (!own_req) begin
                        gnt      <= '0;
                        state    <= IDLE;
                        pchg     <= 1'b0;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                    end else if (pchg_cnt == PCHG_LAST) begin
                        state     <= EVAL;
                        pchg      <= 1'b0;
                        bus_valid <= 1'b1;
                        bus_data  <= ~own_data;
                    end else begin
                        pchg_cnt <= pchg_cnt + PW'(1);
                    end
                end

                EVAL: begin
                    bus_valid <= 1'b0;
                    bus_data  <= {W{BUS_IDLE_LEVEL}};
                    // A requester-marked last beat wins over the limit, so forced stays low then.
                    if (own_last || (beat_next == BEAT_LIMIT)) begin
                        gnt      <= '0;
                        state    <= IDLE;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        forced   <= ~own_last;
                    end else begin
                        state    <= PCHG;
                        pchg     <= 1'b1;
                        pchg_cnt <= '0;
                        beat_cnt <= beat_next;
                    end
                end

                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    pchg      <= 1'b0;
                    bus_valid <= 1'b0;
                    bus_data  <= {W{BUS_IDLE_LEVEL}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_bus_arbiter.sv
// Scoreboard bench for sm83_bus_arbiter: two instances (1 and 3 precharge cycles)
// share stimulus and are compared against a beat-timing reference model.
module tb_sm83_bus_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXB = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*W-1:0]  wdata;

    logic [N-1:0] gnt0, gnt3;
    logic         pchg0, pchg3, bv0, bv3, forced0, forced3;
    logic [W-1:0] bd0, bd3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } beat_t;

    beat_t sb0[$];
    beat_t sb1[$];

    logic [N-1:0] m_gnt    [2];
    logic         m_pchg   [2];
    logic         m_valid  [2];
    logic         m_forced [2];
    logic [W-1:0] m_data   [2];
    int           busy     [2];
    int           owner    [2];
    int           tcnt     [2];
    int           beats    [2];
    int           ptr      [2];

    int run0 = 0;
    int run3 = 0;

    always #5 clk = ~clk;

    sm83_bus_arbiter #(.N_REQ(N), .W(W), .PCHG_CYC(1), .MAX_BEATS(MAXB)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(req), .last(last), .wdata(wdata),
        .gnt(gnt0), .pchg(pchg0), .bus_valid(bv0), .bus_data(bd0), .forced(forced0)
    );

    sm83_bus_arbiter #(.N_REQ(N), .W(W), .PCHG_CYC(3), .MAX_BEATS(MAXB)) dut3 (
        .clk(clk), .reset_n(reset_n), .req(req), .last(last), .wdata(wdata),
        .gnt(gnt3), .pchg(pchg3), .bus_valid(bv3), .bus_data(bd3), .forced(forced3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                                 input logic [N*W-1:0] d, input int cycles);
        req   = r;
        last  = l;
        wdata = d;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: a grant lasts a whole number of beats of (pc+1) cycles,
    // the first pc of each beat precharge and the last one evaluate.
    always @(posedge clk or negedge reset_n) begin
        int    pc;
        int    pos;
        int    cand;
        bit    found;
        beat_t e;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                busy[k] = 0; owner[k] = 0; tcnt[k] = 0; beats[k] = 0; ptr[k] = 0;
                m_gnt[k] = '0; m_pchg[k] = 1'b0; m_valid[k] = 1'b0;
                m_forced[k] = 1'b0; m_data[k] = 8'hFF;
            end
            sb0.delete();
            sb1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                pc = (k == 0) ? 1 : 3;
                m_forced[k] = 1'b0;
                if (busy[k] == 0) begin
                    if (req != '0) begin
                        found = 1'b0;
                        for (int s = 0; s < N; s++) begin
                            cand = (ptr[k] + s) % N;
                            if (!found && req[cand]) begin
                                owner[k] = cand;
                                found    = 1'b1;
                            end
                        end
                        busy[k] = 1; tcnt[k] = 1; beats[k] = 0;
                    end
                end else begin
                    pos = (tcnt[k] - 1) % (pc + 1);
                    if (pos < pc) begin
                        if (!req[owner[k]]) begin
                            busy[k] = 0;
                            ptr[k]  = (owner[k] + 1) % N;
                        end else begin
                            tcnt[k]++;
                        end
                    end else begin
                        beats[k]++;
                        if (last[owner[k]] || beats[k] == MAXB) begin
                            m_forced[k] = !last[owner[k]];
                            busy[k]     = 0;
                            ptr[k]      = (owner[k] + 1) % N;
                        end else begin
                            tcnt[k]++;
                        end
                    end
                end
                if (busy[k] != 0) begin
                    pos        = (tcnt[k] - 1) % (pc + 1);
                    m_gnt[k]   = N'(1 << owner[k]);
                    m_pchg[k]  = (pos < pc);
                    m_valid[k] = (pos == pc);
                    m_data[k]  = m_valid[k] ? ~wdata[owner[k]*W +: W] : 8'hFF;
                    if (m_valid[k]) begin
                        e.idx  = owner[k];
                        e.data = m_data[k];
                        if (k == 0) sb0.push_back(e);
                        else        sb1.push_back(e);
                    end
                end else begin
                    m_gnt[k] = '0; m_pchg[k] = 1'b0; m_valid[k] = 1'b0; m_data[k] = 8'hFF;
                end
            end
        end
    end

    task automatic monitorDut(input int k, input logic [N-1:0] g, input logic p,
                              input logic v, input logic f, input logic [W-1:0] d);
        beat_t e;
        int    qsize;
        checkOutput($sformatf("gnt_k%0d", k),    32'(g), 32'(m_gnt[k]));
        checkOutput($sformatf("pchg_k%0d", k),   32'(p), 32'(m_pchg[k]));
        checkOutput($sformatf("valid_k%0d", k),  32'(v), 32'(m_valid[k]));
        checkOutput($sformatf("forced_k%0d", k), 32'(f), 32'(m_forced[k]));
        checkOutput($sformatf("data_k%0d", k),   32'(d), 32'(m_data[k]));
        checkOutput($sformatf("onehot_k%0d", k), 32'($onehot0(g)), 32'd1);
        if (v) begin
            qsize = (k == 0) ? sb0.size() : sb1.size();
            checkOutput($sformatf("sb_pending_k%0d", k), 32'(qsize != 0), 32'd1);
            if (qsize != 0) begin
                e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                checkOutput($sformatf("beat_data_k%0d", k),  32'(d), 32'(e.data));
                checkOutput($sformatf("beat_owner_k%0d", k), 32'(g), 32'(1 << e.idx));
            end
        end
    endtask

    // Monitor: compare away from the active edge; also count precharge run before each evaluate.
    always @(negedge clk) begin
        monitorDut(0, gnt0, pchg0, bv0, forced0, bd0);
        monitorDut(1, gnt3, pchg3, bv3, forced3, bd3);
        if (pchg0) run0++;
        else begin
            if (bv0) checkOutput("pchg_run_p1", 32'(run0), 32'd1);
            run0 = 0;
        end
        if (pchg3) run3++;
        else begin
            if (bv3) checkOutput("pchg_run_p3", 32'(run3), 32'd3);
            run3 = 0;
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] l;
        int           seen;
        int           waited;

        reset_n = 1'b0;
        req     = '0;
        last    = '0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt",    32'(gnt0),    32'h0);
        checkOutput("rst_pchg",   32'(pchg0),   32'h0);
        checkOutput("rst_valid",  32'(bv0),     32'h0);
        checkOutput("rst_data",   32'(bd0),     32'hFF);
        checkOutput("rst_forced", 32'(forced0), 32'h0);
        checkOutput("rst_data3",  32'(bd3),     32'hFF);

        $display("[TB] single requester 2, last on beat 1");
        reset_n = 1'b1;
        req     = 4'b0100;
        last    = 4'b0100;
        wdata   = {8'h00, 8'h3C, 8'h00, 8'h00};
        @(posedge clk); #1;
        checkOutput("single_gnt",  32'(gnt0),  32'h4);
        checkOutput("single_pchg", 32'(pchg0), 32'h1);
        @(posedge clk); #1;
        checkOutput("single_valid", 32'(bv0), 32'h1);
        checkOutput("single_data",  32'(bd0), 32'hC3);
        @(negedge clk);
        applyStimulus(4'b0100, 4'b0100, {8'h00, 8'h3C, 8'h00, 8'h00}, 10);

        $display("[TB] all requesting, round robin");
        applyStimulus(4'b1111, 4'b1111, $urandom(), 40);

        $display("[TB] requester 1 without last, burst limit");
        applyStimulus(4'b0010, 4'b0000, $urandom(), 30);

        $display("[TB] abort during second precharge");
        applyStimulus(4'b0000, 4'b0000, $urandom(), 6);
        req    = 4'b1000;
        waited = 0;
        while (!bv0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort_wait_beat1", 32'(bv0), 32'h1);
        applyStimulus(4'b0000, 4'b0000, $urandom(), 4);
        req  = 4'b1001;
        last = 4'b1111;
        @(posedge clk); #1;
        checkOutput("abort_next_gnt", 32'(gnt0), 32'h1);
        @(negedge clk);
        applyStimulus(4'b0000, 4'b0000, $urandom(), 6);

        $display("[TB] reset during evaluate of beat 2");
        req    = 4'b0001;
        last   = 4'b0000;
        seen   = 0;
        waited = 0;
        while (seen < 2 && waited < 30) begin
            @(negedge clk);
            waited++;
            if (bv0) seen++;
        end
        checkOutput("beat2_reached", 32'(seen), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_gnt",    32'(gnt0),    32'h0);
        checkOutput("midrst_pchg",   32'(pchg0),   32'h0);
        checkOutput("midrst_valid",  32'(bv0),     32'h0);
        checkOutput("midrst_data",   32'(bd0),     32'hFF);
        checkOutput("midrst_forced", 32'(forced0), 32'h0);
        checkOutput("midrst_gnt3",   32'(gnt3),    32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("fresh_gnt", 32'(gnt0), 32'h1);
        @(negedge clk);

        $display("[TB] randomized traffic");
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if ($urandom_range(9) == 0) r[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    r[i] = 1'b1;
                end
                l[i] = ($urandom_range(2) == 0);
            end
            applyStimulus(r, l, $urandom(), 1);
        end

        applyStimulus(4'b0000, 4'b0000, '0, 20);
        checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);
        checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
